// File: rtl/m2m_pkg.sv
// Shared types and constants for the memory-to-memory copy sequencer.
// Encodes the transfer FSM and the fixed pointer increment.
package m2m_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      WR_REQ  = 3'd2,
      INC_SRC = 3'd3,
      INC_DST = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam int unsigned ADDR_INC = 1;

endpackage

// File: rtl/m2m_transfer_ctrl_adder.sv
// NBitFullAdder: N-bit adder with carry in/out, shared by the copy sequencer.
// A zero PATH_DELAY selects a flat adder; otherwise an explicit ripple chain.
module NBitFullAdder #(
   parameter int BITWIDTH   = 8,
   parameter int PATH_DELAY = 3
) (
   input  logic [BITWIDTH-1:0] i_a,
   input  logic [BITWIDTH-1:0] i_b,
   input  logic                i_cin,
   output logic [BITWIDTH-1:0] o_sum,
   output logic                o_cout
);

   generate
      if (PATH_DELAY > 0) begin : g_ripple
         logic [BITWIDTH:0] w_c;

         assign w_c[0] = i_cin;

         for (genvar i = 0; i < BITWIDTH; i++) begin : g_bit
            assign o_sum[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
            assign w_c[i+1]   = (i_a[i] & i_b[i])
                              | (w_c[i] & (i_a[i] ^ i_b[i]));
         end

         assign o_cout = w_c[BITWIDTH];
      end else begin : g_flat
         logic [BITWIDTH:0] w_full;

         assign w_full = {1'b0, i_a} + {1'b0, i_b}
                       + {{BITWIDTH{1'b0}}, i_cin};
         assign o_sum  = w_full[BITWIDTH-1:0];
         assign o_cout = w_full[BITWIDTH];
      end
   endgenerate

endmodule

// File: rtl/m2m_transfer_ctrl.sv
// Memory-to-memory block copy sequencer: alternating read/write requests
// on one memory port, with a single shared adder stepping both pointers.
module m2m_transfer_ctrl
   import m2m_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 9,
   parameter int PATH_DELAY = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src_base,
   input  logic [ADDR_WIDTH-1:0] dst_base,
   input  logic [LEN_WIDTH-1:0]  length,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack
);

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_WIDTH-1:0] r_src_ptr;
   logic [ADDR_WIDTH-1:0] r_dst_ptr;
   logic [LEN_WIDTH-1:0]  r_remaining;
   logic [DATA_WIDTH-1:0] r_data;
   logic [ADDR_WIDTH-1:0] w_add_a;
   logic [ADDR_WIDTH-1:0] w_add_b;
   logic [ADDR_WIDTH-1:0] w_sum;
   logic                  w_unused_cout;

   // Carry out is dropped so pointers wrap modulo 2^ADDR_WIDTH.
   assign w_add_a = (r_state == INC_SRC) ? r_src_ptr : r_dst_ptr;
   assign w_add_b = ADDR_WIDTH'(ADDR_INC);

   NBitFullAdder #(
      .BITWIDTH   (ADDR_WIDTH),
      .PATH_DELAY (PATH_DELAY)
   ) u_adder (
      .i_a    (w_add_a),
      .i_b    (w_add_b),
      .i_cin  (1'b0),
      .o_sum  (w_sum),
      .o_cout (w_unused_cout)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_next = (length == '0) ? DONE : RD_REQ;
            end
         end
         RD_REQ: begin
            if (mem_ack) w_next = WR_REQ;
         end
         WR_REQ: begin
            if (mem_ack) w_next = INC_SRC;
         end
         INC_SRC: w_next = INC_DST;
         INC_DST: begin
            w_next = (r_remaining == LEN_WIDTH'(1)) ? DONE : RD_REQ;
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_src_ptr   <= '0;
         r_dst_ptr   <= '0;
         r_remaining <= '0;
         r_data      <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start && (length != '0)) begin
                  r_src_ptr   <= src_base;
                  r_dst_ptr   <= dst_base;
                  r_remaining <= length;
               end
            end
            RD_REQ: begin
               if (mem_ack) r_data <= mem_rdata;
            end
            INC_SRC: r_src_ptr <= w_sum;
            INC_DST: begin
               r_dst_ptr   <= w_sum;
               r_remaining <= r_remaining - LEN_WIDTH'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy      = (r_state != IDLE);
      done      = (r_state == DONE);
      mem_req   = (r_state == RD_REQ) || (r_state == WR_REQ);
      mem_we    = (r_state == WR_REQ);
      mem_addr  = '0;
      mem_wdata = '0;
      if (r_state == RD_REQ) begin
         mem_addr = r_src_ptr;
      end else if (r_state == WR_REQ) begin
         mem_addr  = r_dst_ptr;
         mem_wdata = r_data;
      end
   end

endmodule

// File: tb/tb_m2m_transfer_ctrl.sv
// Self-checking bench for m2m_transfer_ctrl: directed table rows,
// hand-written reset/start-while-busy sequences and randomized transfers.
module tb_m2m_transfer_ctrl;

   typedef struct packed {
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
   } txn_t;

   typedef struct {
      string      nm;
      logic [7:0] s;
      logic [7:0] d;
      logic [8:0] n;
      int         rw;
      int         ww;
      int         busy;
      int         poke;
   } vec_t;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] src_base;
   logic [7:0] dst_base;
   logic [8:0] length;
   logic       busy;
   logic       done;
   logic       mem_req;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic       mem_ack;

   int checks   = 0;
   int failures = 0;

   logic [7:0] mem [256];
   txn_t       log_q[$];
   txn_t       exp_q[$];

   bit         rnd_mode;
   int         rw_cfg;
   int         ww_cfg;
   bit         pend;
   int         cnt;
   int         need;
   int         wait_total;
   logic [7:0] p_addr;
   logic [7:0] p_wd;
   logic       p_we;
   int         busy_n;
   int         done_n;
   int         done_at;
   int         stable_err;
   int         idle_err;

   vec_t vt[6];

   m2m_transfer_ctrl #(
      .ADDR_WIDTH (8),
      .DATA_WIDTH (8),
      .LEN_WIDTH  (9),
      .PATH_DELAY (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .src_base  (src_base),
      .dst_base  (dst_base),
      .length    (length),
      .busy      (busy),
      .done      (done),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // One clock: observe DUT just after the edge, then act as the memory.
   task automatic step();
      @(posedge clk);
      #1;
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
         done_n++;
         done_at = busy_n;
      end
      if (mem_req === 1'b1 && busy !== 1'b1) idle_err++;
      mem_ack   = 1'b0;
      mem_rdata = 8'($urandom);
      if (mem_req === 1'b1) begin
         if (!pend) begin
            pend   = 1'b1;
            p_addr = mem_addr;
            p_we   = mem_we;
            p_wd   = mem_wdata;
            cnt    = 0;
            if (rnd_mode) need = int'($urandom_range(0, 3));
            else          need = mem_we ? ww_cfg : rw_cfg;
            wait_total += need;
         end else if (mem_addr !== p_addr || mem_we !== p_we ||
                      (p_we && mem_wdata !== p_wd)) begin
            stable_err++;
         end
         if (cnt == need) begin
            mem_ack = 1'b1;
            if (!p_we) begin
               mem_rdata = mem[p_addr];
               log_q.push_back('{we: 1'b0, addr: p_addr, data: mem[p_addr]});
            end else begin
               mem[p_addr] = p_wd;
               log_q.push_back('{we: 1'b1, addr: p_addr, data: p_wd});
            end
            pend = 1'b0;
         end else begin
            cnt++;
         end
      end else if (rnd_mode) begin
         mem_ack = 1'($urandom);
      end
   endtask

   task automatic clear_obs();
      log_q.delete();
      busy_n     = 0;
      done_n     = 0;
      done_at    = -1;
      wait_total = 0;
      stable_err = 0;
      idle_err   = 0;
      pend       = 1'b0;
   endtask

   task automatic run_xfer(input string nm, input logic [7:0] s,
                           input logic [7:0] d, input logic [8:0] n,
                           input int rw, input int ww, input bit rnd,
                           input int exp_busy, input int poke);
      logic [7:0] tmp [256];
      logic [7:0] a;
      logic [7:0] v;
      int         guard;
      int         expb;
      tmp = mem;
      exp_q.delete();
      for (int i = 0; i < int'(n); i++) begin
         a = 8'(int'(s) + i);
         v = tmp[a];
         exp_q.push_back('{we: 1'b0, addr: a, data: v});
         a = 8'(int'(d) + i);
         tmp[a] = v;
         exp_q.push_back('{we: 1'b1, addr: a, data: v});
      end
      clear_obs();
      rnd_mode = rnd;
      rw_cfg   = rw;
      ww_cfg   = ww;
      src_base = s;
      dst_base = d;
      length   = n;
      start    = 1'b1;
      step();
      start = 1'b0;
      guard = 0;
      while (busy === 1'b1 && guard < 4000) begin
         if (busy_n == poke) begin
            start    = 1'b1;
            src_base = ~s;
            dst_base = ~d;
            length   = 9'd5;
         end else begin
            start = 1'b0;
         end
         step();
         guard++;
      end
      start = 1'b0;
      chk({nm, " ended"}, {31'd0, busy}, 32'd0);
      if (exp_busy >= 0) expb = exp_busy;
      else if (n == 0)   expb = 1;
      else               expb = 4 * int'(n) + wait_total + 1;
      chk({nm, " busy_cycles"}, busy_n, expb);
      chk({nm, " done_count"}, done_n, 1);
      chk({nm, " done_cycle"}, done_at, busy_n);
      chk({nm, " held_stable"}, stable_err, 0);
      chk({nm, " req_idle"}, idle_err, 0);
      chk({nm, " txn_count"}, log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         chk({nm, " txn"}, 32'(log_q[i]), 32'(exp_q[i]));
      end
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      src_base  = '0;
      dst_base  = '0;
      length    = '0;
      mem_rdata = '0;
      mem_ack   = 1'b0;
      rnd_mode  = 1'b0;
      rw_cfg    = 0;
      ww_cfg    = 0;
      clear_obs();
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

      vt[0] = '{"basic",    8'h10, 8'h80, 9'd3,   0, 0, 13,   -1};
      vt[1] = '{"zero_len", 8'h33, 8'h44, 9'd0,   0, 0, 1,    -1};
      vt[2] = '{"waits",    8'h40, 8'h50, 9'd1,   2, 3, 10,   -1};
      vt[3] = '{"wrap",     8'hFE, 8'hFF, 9'd3,   0, 0, 13,   -1};
      vt[4] = '{"start_bz", 8'h20, 8'h30, 9'd3,   0, 0, 13,   5};
      vt[5] = '{"long",     8'h05, 8'hF0, 9'd260, 0, 0, 1041, -1};

      #3;
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst req_we", {30'd0, mem_req, mem_we}, 32'd0);
      chk("rst addr", {24'd0, mem_addr}, 32'd0);
      chk("rst wdata", {24'd0, mem_wdata}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) step();

      for (int i = 0; i < 6; i++) begin
         if (i == 0) begin
            mem[8'h10] = 8'hA1;
            mem[8'h11] = 8'hA2;
            mem[8'h12] = 8'hA3;
         end
         run_xfer(vt[i].nm, vt[i].s, vt[i].d, vt[i].n, vt[i].rw,
                  vt[i].ww, 1'b0, vt[i].busy, vt[i].poke);
         if (i == 0 && log_q.size() == 6) begin
            for (int k = 0; k < 3; k++) begin
               chk("basic write",
                   {15'd0, log_q[2*k+1].we, log_q[2*k+1].addr,
                    log_q[2*k+1].data},
                   {15'd0, 1'b1, 8'(8'h80 + k), 8'(8'hA1 + k)});
            end
         end
      end

      // Abort in the write request of word 2 of 4.
      clear_obs();
      src_base = 8'h60;
      dst_base = 8'h70;
      length   = 9'd4;
      start    = 1'b1;
      step();
      start = 1'b0;
      repeat (5) step();
      chk("abort pre req_we", {30'd0, mem_req, mem_we}, 32'd3);
      chk("abort pre addr", {24'd0, mem_addr}, 32'h71);
      #2;
      reset = 1'b1;
      #1;
      chk("abort req", {31'd0, mem_req}, 32'd0);
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort done", {31'd0, done}, 32'd0);
      mem_ack = 1'b0;
      clear_obs();
      @(negedge clk);
      reset = 1'b0;
      repeat (4) step();
      chk("abort no_done", done_n, 0);
      chk("abort idle", busy_n, 0);
      run_xfer("after_rst", 8'hC0, 8'hD0, 9'd2, 1, 0, 1'b0, 11, -1);

      for (int r = 0; r < 25; r++) begin
         run_xfer("rand", 8'($urandom), 8'($urandom),
                  9'($urandom_range(0, 12)), 0, 0, 1'b1, -1, -1);
      end
      rnd_mode = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
